game_flow_ctrl: RTL and testbench
=================================

// Module: game_flow_ctrl
// PURPOSE
//  Frame-synchronous game sequencer for the flappy-bird datapath. Sits between the
//  push-buttons/renderer and the VGA pixel logic. Runs the IDLE/PLAY/DYING/OVER state
//  machine, integrates bird velocity and position once per video frame, gates pipe
//  scrolling and keeps a 4-digit BCD score for the HEX displays.
// PARAMETERS
//  GRAVITY      1    velocity increment per frame (px/frame^2)
//  FLAP_VEL     6    upward speed loaded on a flap (px/frame)
//  MAX_FALL     8    downward velocity ceiling (px/frame)
//  BIRD_Y0      240  bird rest row in IDLE and after restart
//  Y_MAX        464  ground row; bird y is clamped to [0, Y_MAX]
//  DEATH_FRAMES 60   maximum frames spent in DYING
// PORTS
//  iCLK         in   1   system clock (CLOCK_50 domain)
//  iRST_N       in   1   reset, synchronous, active-low
//  iFrame_tick  in   1   one-cycle pulse per frame, start of vertical blank
//  iFlap_n      in   1   flap button, active-low, already synchronised
//  iStart_n     in   1   restart button, active-low, already synchronised
//  iCollide     in   1   bird/pipe overlap flag from renderer; level, sampled on tick
//  iPipe_pass   in   1   one-cycle pulse when a pipe clears the bird column
//  oState       out  2   0=IDLE 1=PLAY 2=DYING 3=OVER
//  oBird_y      out  10  bird top row, unsigned
//  oScroll_en   out  1   pipes advance on ticks while high
//  oPipe_reset  out  1   one-cycle pulse: pipe generator returns to start layout
//  oScore_bcd   out  16  {thousands,hundreds,tens,units} BCD
// BEHAVIOUR
//  - Reset (iRST_N=0 at an edge): state IDLE, oBird_y=BIRD_Y0, vel=0, score 0x0000,
//    oScroll_en=0, oPipe_reset=0, pending flags cleared. Applies mid-game; wins over all.
//  - Flap/start edges: 1->0 transition of iFlap_n / iStart_n, detected with one register
//    stage; a held button yields exactly one edge. Flap edge latches flap_pend until consumed.
//  - vel: 6-bit signed, positive = down. All position/velocity updates occur only in the
//    cycle iFrame_tick=1; results are visible the following cycle (latency 1).
//  - PLAY tick: vel_n = flap_pend ? -FLAP_VEL : min(vel+GRAVITY, MAX_FALL);
//    y_n = clamp(y + vel_n, 0, Y_MAX) (compute in 11-bit signed); flap_pend cleared.
//    If iCollide=1 or y+vel_n >= Y_MAX -> DYING, death counter cleared.
//  - IDLE: y held at BIRD_Y0, vel=0. Flap edge -> PLAY next cycle, flap_pend stays set
//    so the first PLAY tick applies a flap. Start edges ignored.
//  - DYING: flaps ignored and flap_pend cleared; each tick vel_n = min(vel+GRAVITY,
//    MAX_FALL), y_n clamped as above, counter++. -> OVER when y_n = Y_MAX or counter
//    reaches DEATH_FRAMES, whichever first.
//  - OVER: y, vel frozen. Start edge -> IDLE: oPipe_reset=1 for one cycle, score cleared,
//    y=BIRD_Y0, vel=0. Flap edges ignored.
//  - oScroll_en registered: 1 exactly while state=PLAY.
//  - Score: iPipe_pass in PLAY increments BCD with carry; saturates at 9999. Pulses
//    outside PLAY ignored. Pass and collision in the same cycle: pass counts.
//  - Tick arriving with flap edge in same cycle (PLAY): edge is applied this tick.
//  - Ticks closer than 1 cycle apart are not supported.
// STRUCTURE
//  - Shared package game_pkg: state encodings (ST_IDLE..ST_OVER), screen constants
//    (H_RES=640, V_RES=480), default Y_MAX/BIRD_Y0 so renderer and controller agree.
//  - Sub-module bcd_counter4: 4-digit BCD incrementer, sync clear, saturate at 9999.
//  - Edge detectors, physics integrator and FSM inline.
// TESTING
//  1 Reset: iRST_N=0 for 3 cycles -> oState=0, oBird_y=240, oScore_bcd=0x0000,
//    oScroll_en=0, oPipe_reset=0.
//  2 IDLE, flap edge then tick -> oState=1, oBird_y=234; next tick, no flap -> 229, then 225.
//  3 PLAY free fall from vel=-6: per-tick y deltas -5,-4,...,7,8,8,8; clamps at 464 and
//    enters DYING on the tick that reaches 464.
//  4 PLAY, iCollide=1 on a tick at y=100 -> oState=2 and oScroll_en=0 next cycle;
//    flaps ignored; oState=3 after at most 60 ticks or on reaching y=464.
//  5 12 iPipe_pass pulses in PLAY -> 0x0012; 3 pulses in OVER -> unchanged; 10000
//    pulses -> 0x9999.
//  6 OVER, iStart_n held low 100 cycles -> one oPipe_reset pulse, oState=0,
//    oScore_bcd=0x0000, oBird_y=240; iRST_N=0 mid-PLAY -> all reset values next cycle.

Source files
------------

// File: rtl/game_pkg.sv
// Shared definitions for the flappy-bird datapath: FSM state encodings, screen
// geometry and the bird rest/ground rows used by both renderer and controller.
package game_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_PLAY  = 2'd1,
        ST_DYING = 2'd2,
        ST_OVER  = 2'd3
    } game_state_t;

    localparam int H_RES       = 640;
    localparam int V_RES       = 480;
    localparam int Y_MAX_DEF   = 464;
    localparam int BIRD_Y0_DEF = 240;

    // One BCD digit step: returns {carry_out, next_digit}.
    function automatic logic [4:0] bcd_digit_inc(input logic [3:0] digit, input logic carry_in);
        if (!carry_in) begin
            return {1'b0, digit};
        end else if (digit == 4'd9) begin
            return {1'b1, 4'd0};
        end else begin
            return {1'b0, digit + 4'd1};
        end
    endfunction

endpackage

// File: rtl/bcd_counter4.sv
// Four-digit BCD event counter with synchronous clear; holds at 9999 instead of wrapping.
module bcd_counter4
    import game_pkg::*;
(
    input  logic        i_clk,
    input  logic        i_rst_n,
    input  logic        i_clr,
    input  logic        i_inc,
    output logic [15:0] o_bcd
);

    logic [15:0] r_bcd;
    logic [15:0] w_next;
    logic        w_c1;
    logic        w_c2;
    logic        w_c3;
    logic [4:0]  w_top;
    logic        w_sat;

    // Ripple the increment through the digits; a carry out of the thousands means 9999.
    always_comb begin
        {w_c1, w_next[3:0]}  = bcd_digit_inc(r_bcd[3:0],   1'b1);
        {w_c2, w_next[7:4]}  = bcd_digit_inc(r_bcd[7:4],   w_c1);
        {w_c3, w_next[11:8]} = bcd_digit_inc(r_bcd[11:8],  w_c2);
        w_top                = bcd_digit_inc(r_bcd[15:12], w_c3);
        w_next[15:12]        = w_top[3:0];
        w_sat                = w_top[4];
    end

    // Count register: reset and clear win over increment.
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_bcd <= 16'h0000;
        end else if (i_clr) begin
            r_bcd <= 16'h0000;
        end else if (i_inc && !w_sat) begin
            r_bcd <= w_next;
        end else begin
            r_bcd <= r_bcd;
        end
    end

    assign o_bcd = r_bcd;

endmodule

// File: rtl/game_flow_ctrl.sv
// Frame-synchronous game sequencer: IDLE/PLAY/DYING/OVER FSM, per-frame bird
// physics, pipe scroll gating and BCD score keeping.
module game_flow_ctrl
    import game_pkg::*;
#(
    parameter int GRAVITY      = 1,
    parameter int FLAP_VEL     = 6,
    parameter int MAX_FALL     = 8,
    parameter int BIRD_Y0      = BIRD_Y0_DEF,
    parameter int Y_MAX        = Y_MAX_DEF,
    parameter int DEATH_FRAMES = 60
)(
    input  logic        iCLK,
    input  logic        iRST_N,
    input  logic        iFrame_tick,
    input  logic        iFlap_n,
    input  logic        iStart_n,
    input  logic        iCollide,
    input  logic        iPipe_pass,
    output logic [1:0]  oState,
    output logic [9:0]  oBird_y,
    output logic        oScroll_en,
    output logic        oPipe_reset,
    output logic [15:0] oScore_bcd
);

    localparam int CNT_W = $clog2(DEATH_FRAMES + 1);

    localparam logic signed [6:0]  L_GRAV   = 7'(GRAVITY);
    localparam logic signed [6:0]  L_MAXF   = 7'(MAX_FALL);
    localparam logic signed [5:0]  L_FLAP   = 6'(-FLAP_VEL);
    localparam logic signed [10:0] L_YMAX_S = 11'(Y_MAX);
    localparam logic [9:0]         L_YMAX   = 10'(Y_MAX);
    localparam logic [9:0]         L_Y0     = 10'(BIRD_Y0);
    localparam logic [CNT_W-1:0]   L_DEATH  = CNT_W'(DEATH_FRAMES);
    localparam logic [CNT_W-1:0]   L_ONE    = CNT_W'(1);

    game_state_t        r_state;
    logic [9:0]         r_bird_y;
    logic signed [5:0]  r_vel;
    logic [CNT_W-1:0]   r_death_cnt;
    logic               r_flap_d;
    logic               r_start_d;
    logic               r_flap_pend;
    logic               r_scroll_en;
    logic               r_pipe_reset;

    logic               w_flap_edge;
    logic               w_start_edge;
    logic               w_flap_now;
    logic signed [6:0]  w_vel_grav;
    logic signed [5:0]  w_vel_fall;
    logic signed [5:0]  w_vel_n;
    logic signed [10:0] w_y_sum;
    logic [9:0]         w_y_clamp;
    logic               w_hit_ground;
    logic [CNT_W-1:0]   w_cnt_inc;
    logic               w_score_inc;
    logic               w_score_clr;

    assign w_flap_edge  = r_flap_d  & ~iFlap_n;
    assign w_start_edge = r_start_d & ~iStart_n;
    assign w_flap_now   = r_flap_pend | w_flap_edge;
    assign w_cnt_inc    = r_death_cnt + L_ONE;
    assign w_score_inc  = (r_state == ST_PLAY) && iPipe_pass;
    assign w_score_clr  = (r_state == ST_OVER) && w_start_edge;

    // Next-frame velocity and clamped position; a flap only overrides gravity in PLAY.
    always_comb begin
        w_vel_grav = $signed({r_vel[5], r_vel}) + L_GRAV;
        if (w_vel_grav > L_MAXF) begin
            w_vel_fall = L_MAXF[5:0];
        end else begin
            w_vel_fall = w_vel_grav[5:0];
        end

        if ((r_state == ST_PLAY) && w_flap_now) begin
            w_vel_n = L_FLAP;
        end else begin
            w_vel_n = w_vel_fall;
        end

        w_y_sum      = $signed({1'b0, r_bird_y}) + $signed({{5{w_vel_n[5]}}, w_vel_n});
        w_hit_ground = (w_y_sum >= L_YMAX_S);

        if (w_y_sum < 11'sd0) begin
            w_y_clamp = 10'd0;
        end else if (w_hit_ground) begin
            w_y_clamp = L_YMAX;
        end else begin
            w_y_clamp = w_y_sum[9:0];
        end
    end

    // Game FSM with physics state; scroll enable tracks the state it is registered with.
    always_ff @(posedge iCLK) begin
        if (!iRST_N) begin
            r_state      <= ST_IDLE;
            r_bird_y     <= L_Y0;
            r_vel        <= 6'sd0;
            r_death_cnt  <= '0;
            r_flap_d     <= 1'b1;
            r_start_d    <= 1'b1;
            r_flap_pend  <= 1'b0;
            r_scroll_en  <= 1'b0;
            r_pipe_reset <= 1'b0;
        end else begin
            r_flap_d     <= iFlap_n;
            r_start_d    <= iStart_n;
            r_pipe_reset <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    r_bird_y <= L_Y0;
                    r_vel    <= 6'sd0;
                    if (w_flap_edge) begin
                        r_state     <= ST_PLAY;
                        r_scroll_en <= 1'b1;
                        r_flap_pend <= 1'b1;
                    end else begin
                        r_scroll_en <= 1'b0;
                        r_flap_pend <= 1'b0;
                    end
                end
                ST_PLAY: begin
                    if (iFrame_tick) begin
                        r_vel       <= w_vel_n;
                        r_bird_y    <= w_y_clamp;
                        r_flap_pend <= 1'b0;
                        if (iCollide || w_hit_ground) begin
                            r_state     <= ST_DYING;
                            r_scroll_en <= 1'b0;
                            r_death_cnt <= '0;
                        end else begin
                            r_scroll_en <= 1'b1;
                        end
                    end else if (w_flap_edge) begin
                        r_flap_pend <= 1'b1;
                    end else begin
                        r_flap_pend <= r_flap_pend;
                    end
                end
                ST_DYING: begin
                    r_flap_pend <= 1'b0;
                    r_scroll_en <= 1'b0;
                    if (iFrame_tick) begin
                        r_vel       <= w_vel_n;
                        r_bird_y    <= w_y_clamp;
                        r_death_cnt <= w_cnt_inc;
                        if ((w_y_clamp == L_YMAX) || (w_cnt_inc >= L_DEATH)) begin
                            r_state <= ST_OVER;
                        end else begin
                            r_state <= ST_DYING;
                        end
                    end else begin
                        r_state <= ST_DYING;
                    end
                end
                ST_OVER: begin
                    r_flap_pend <= 1'b0;
                    r_scroll_en <= 1'b0;
                    if (w_start_edge) begin
                        r_state      <= ST_IDLE;
                        r_pipe_reset <= 1'b1;
                        r_bird_y     <= L_Y0;
                        r_vel        <= 6'sd0;
                    end else begin
                        r_state <= ST_OVER;
                    end
                end
                default: begin
                    r_state     <= ST_IDLE;
                    r_bird_y    <= L_Y0;
                    r_vel       <= 6'sd0;
                    r_flap_pend <= 1'b0;
                    r_scroll_en <= 1'b0;
                end
            endcase
        end
    end

    bcd_counter4 u_score (
        .i_clk   (iCLK),
        .i_rst_n (iRST_N),
        .i_clr   (w_score_clr),
        .i_inc   (w_score_inc),
        .o_bcd   (oScore_bcd)
    );

    assign oState      = r_state;
    assign oBird_y     = r_bird_y;
    assign oScroll_en  = r_scroll_en;
    assign oPipe_reset = r_pipe_reset;

endmodule

// File: tb/tb_game_flow_ctrl.sv
// Directed bench for game_flow_ctrl: reset, flap/free-fall physics, collision and
// death timeout, score counting/saturation, restart and mid-game reset.
module tb_game_flow_ctrl;

    logic        iCLK = 1'b0;
    logic        iRST_N;
    logic        iFrame_tick;
    logic        iFlap_n;
    logic        iStart_n;
    logic        iCollide;
    logic        iPipe_pass;
    logic [1:0]  oState;
    logic [9:0]  oBird_y;
    logic        oScroll_en;
    logic        oPipe_reset;
    logic [15:0] oScore_bcd;

    int n_total = 0;
    int n_pass  = 0;
    int n_fail  = 0;

    // Reference model of the game (states 0..3, y, velocity, death counter, pending flap)
    int m_st, m_y, m_v, m_cnt, m_pend;

    always #5 iCLK = ~iCLK;

    game_flow_ctrl dut (
        .iCLK        (iCLK),
        .iRST_N      (iRST_N),
        .iFrame_tick (iFrame_tick),
        .iFlap_n     (iFlap_n),
        .iStart_n    (iStart_n),
        .iCollide    (iCollide),
        .iPipe_pass  (iPipe_pass),
        .oState      (oState),
        .oBird_y     (oBird_y),
        .oScroll_en  (oScroll_en),
        .oPipe_reset (oPipe_reset),
        .oScore_bcd  (oScore_bcd)
    );

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) @(posedge iCLK);
        #1;
    endtask

    task automatic model_idle();
        m_st = 0; m_y = 240; m_v = 0; m_cnt = 0; m_pend = 0;
    endtask

    // Flap press with no tick, then release.
    task automatic flap();
        iFlap_n = 1'b0;
        cyc(1);
        iFlap_n = 1'b1;
        cyc(1);
        if (m_st == 0) begin
            m_st = 1; m_pend = 1;
        end else if (m_st == 1) begin
            m_pend = 1;
        end
    endtask

    // One frame tick, optionally with a flap edge and collision in the same cycle.
    task automatic do_tick(input bit fl, input bit col);
        int s;
        iFrame_tick = 1'b1;
        iFlap_n     = fl ? 1'b0 : 1'b1;
        iCollide    = col;
        cyc(1);
        iFrame_tick = 1'b0;
        iFlap_n     = 1'b1;
        iCollide    = 1'b0;
        iPipe_pass  = 1'b0;
        cyc(1);
        if (m_st == 0) begin
            if (fl) begin
                m_st = 1; m_pend = 1;
            end
        end else if (m_st == 1) begin
            m_v    = (fl || m_pend != 0) ? -6 : ((m_v + 1 > 8) ? 8 : m_v + 1);
            m_pend = 0;
            s      = m_y + m_v;
            m_y    = (s < 0) ? 0 : ((s > 464) ? 464 : s);
            if (col || s >= 464) begin
                m_st = 2; m_cnt = 0;
            end
        end else if (m_st == 2) begin
            m_v   = (m_v + 1 > 8) ? 8 : m_v + 1;
            s     = m_y + m_v;
            m_y   = (s < 0) ? 0 : ((s > 464) ? 464 : s);
            m_cnt = m_cnt + 1;
            if (m_y == 464 || m_cnt >= 60) m_st = 3;
        end
        check("tick_y", {6'd0, oBird_y}, 16'(m_y));
        check("tick_state", {14'd0, oState}, 16'(m_st));
    endtask

    task automatic pulses(input int n);
        iPipe_pass = 1'b1;
        cyc(n);
        iPipe_pass = 1'b0;
        cyc(1);
    endtask

    task automatic restart();
        iStart_n = 1'b0;
        cyc(1);
        iStart_n = 1'b1;
        cyc(1);
        model_idle();
    endtask

    initial begin
        int n_pr;
        iRST_N = 1'b0; iFrame_tick = 1'b0; iFlap_n = 1'b1; iStart_n = 1'b1;
        iCollide = 1'b0; iPipe_pass = 1'b0;
        model_idle();

        // Reset
        cyc(3);
        check("rst_state", {14'd0, oState}, 16'd0);
        check("rst_y", {6'd0, oBird_y}, 16'd240);
        check("rst_score", oScore_bcd, 16'h0000);
        check("rst_scroll", {15'd0, oScroll_en}, 16'd0);
        check("rst_pipe_reset", {15'd0, oPipe_reset}, 16'd0);
        iRST_N = 1'b1;
        cyc(1);

        // Start edges ignored in IDLE; flap edge enters PLAY
        restart();
        check("idle_start_ignored", {14'd0, oState}, 16'd0);
        flap();
        check("play_state", {14'd0, oState}, 16'd1);
        check("play_scroll", {15'd0, oScroll_en}, 16'd1);
        check("play_y_hold", {6'd0, oBird_y}, 16'd240);
        do_tick(0, 0);
        check("first_tick_y", {6'd0, oBird_y}, 16'd234);
        do_tick(0, 0);
        check("second_tick_y", {6'd0, oBird_y}, 16'd229);
        do_tick(0, 0);
        check("third_tick_y", {6'd0, oBird_y}, 16'd225);

        // Score in PLAY
        pulses(12);
        check("score_12", oScore_bcd, 16'h0012);

        // Free fall to the ground, then one DYING tick to OVER
        for (int k = 0; k < 50; k++) begin
            do_tick(0, 0);
            if (m_st != 1) break;
        end
        check("fall_dying", {14'd0, oState}, 16'd2);
        check("fall_ground", {6'd0, oBird_y}, 16'd464);
        check("dying_scroll", {15'd0, oScroll_en}, 16'd0);
        do_tick(0, 0);
        check("ground_over", {14'd0, oState}, 16'd3);

        // OVER: passes and flaps ignored
        pulses(3);
        check("over_score_hold", oScore_bcd, 16'h0012);
        flap();
        check("over_flap_ignored", {14'd0, oState}, 16'd3);

        // Held start: exactly one pipe reset pulse
        iStart_n = 1'b0;
        n_pr = 0;
        for (int k = 0; k < 100; k++) begin
            cyc(1);
            if (oPipe_reset) n_pr++;
        end
        iStart_n = 1'b1;
        cyc(1);
        model_idle();
        check("pipe_reset_count", 16'(n_pr), 16'd1);
        check("restart_state", {14'd0, oState}, 16'd0);
        check("restart_score", oScore_bcd, 16'h0000);
        check("restart_y", {6'd0, oBird_y}, 16'd240);

        // Climb to y=100, then collide with a simultaneous pipe pass
        flap();
        do_tick(0, 0);
        for (int k = 0; k < 20; k++) do_tick(1, 0);
        for (int k = 0; k < 4; k++) do_tick(0, 0);
        check("climb_y100", {6'd0, oBird_y}, 16'd100);
        iPipe_pass = 1'b1;
        do_tick(0, 1);
        check("collide_state", {14'd0, oState}, 16'd2);
        check("collide_scroll", {15'd0, oScroll_en}, 16'd0);
        check("collide_pass_counts", oScore_bcd, 16'h0001);
        flap();
        for (int k = 0; k < 70; k++) begin
            do_tick(0, 0);
            if (m_st == 3) break;
        end
        check("collide_over", {14'd0, oState}, 16'd3);
        check("collide_over_y", {6'd0, oBird_y}, 16'd464);

        // Top clamp, then collision high up: OVER via the death-frame limit
        restart();
        flap();
        for (int k = 0; k < 45; k++) do_tick(1, 0);
        check("top_clamp_y", {6'd0, oBird_y}, 16'd0);
        check("top_clamp_play", {14'd0, oState}, 16'd1);
        do_tick(0, 1);
        for (int k = 0; k < 70; k++) begin
            do_tick(0, 0);
            if (m_st == 3) break;
        end
        check("limit_over", {14'd0, oState}, 16'd3);
        check("limit_cnt", 16'(m_cnt), 16'd60);
        check("limit_y", {6'd0, oBird_y}, 16'd412);

        // Score saturation
        restart();
        flap();
        pulses(10000);
        check("score_sat", oScore_bcd, 16'h9999);
        pulses(1);
        check("score_sat_hold", oScore_bcd, 16'h9999);

        // Mid-PLAY reset
        do_tick(0, 0);
        iRST_N = 1'b0;
        cyc(1);
        check("midrst_state", {14'd0, oState}, 16'd0);
        check("midrst_y", {6'd0, oBird_y}, 16'd240);
        check("midrst_score", oScore_bcd, 16'h0000);
        check("midrst_scroll", {15'd0, oScroll_en}, 16'd0);
        check("midrst_pipe_reset", {15'd0, oPipe_reset}, 16'd0);
        iRST_N = 1'b1;
        cyc(2);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
